target_spawner: RTL and testbench
=================================

// Module: target_spawner
// PURPOSE
//  Consumes the random generator's target index (0..9) and length code; schedules,
//  activates, times out and scores on-screen targets for the game.
//  Sits directly downstream of the generator.
//  Its score output feeds back to the generator's score input, so score never drops below SCORE_FLOOR.
// PARAMETERS
//  SPAWN_PERIOD  1000  cycles between spawn attempts (>=2)
//  LIFE_UNIT     256   cycles of target lifetime per length unit
//  FIFO_DEPTH    4     pending-target queue depth (power of 2)
//  MISS_PENALTY  2     score decrement per expired target
//  SCORE_FLOOR   10    minimum score; also the reset value (generator modulus stays nonzero)
// PORTS
//  clk            in   1   clock, all state on posedge
//  resetn         in   1   asynchronous active-low reset
//  enable         in   1   1 = run, 0 = pause (timers, lifetimes and hits frozen)
//  ran_num_ten    in   32  target index from generator, valid range 0..9
//  ran_num_length in   32  length code from generator; only value%5 used
//  hit_valid      in   1   player hit strobe, one cycle
//  hit_slot       in   4   slot of the hit
//  target_mask    out  10  bit i = target i active
//  hit_ok         out  1   one-cycle pulse: accepted hit
//  miss_pulse     out  1   one-cycle pulse: >=1 target expired this cycle
//  overflow_pulse out  1   one-cycle pulse: spawn dropped (queue full or index >9)
//  queue_count    out  3   pending entries, 0..FIFO_DEPTH
//  score          out  32  running score
// BEHAVIOUR
//  Reset: target_mask=0, all pulses=0, queue_count=0, score=SCORE_FLOOR, spawn timer=0,
//   lifetimes=0. A reset mid-operation discards the queue and all active targets immediately.
//  Spawn timer (enable=1): counts 0..SPAWN_PERIOD-1 and wraps. At terminal count it samples both
//   inputs and forms entry {slot=ran_num_ten[3:0], life=(ran_num_length%5)+1}.
//   - If ran_num_ten>9 or the queue is full: entry dropped, overflow_pulse=1.
//   - Otherwise: entry pushed, visible in queue_count the next cycle.
//  Dispatch (enable=1): each cycle, if the queue is non-empty and the head slot's
//   target_mask bit (registered value) is 0:
//   - the head is popped, its mask bit is set, and its lifetime = life*LIFE_UNIT;
//   - the target is visible 1 cycle after the pop decision.
//   If the head slot is active, the queue stalls (strict in-order, head-of-line blocking).
//   A push and a pop in the same cycle are legal; queue_count is unchanged.
//  Lifetime: every active slot decrements each enabled cycle. On reaching 0:
//   - the mask bit clears;
//   - counted as expired.
//  Hit (enable=1): hit_slot<=9 with its mask bit set:
//   - clears the bit and its lifetime;
//   - hit_ok=1 the next cycle.
//   A hit on an inactive slot or hit_slot>9 is ignored, with no penalty.
//   Hit and expiry on the same slot in the same cycle: the hit wins, no miss.
//   A slot freed by a hit is dispatchable the following cycle, not the same cycle.
//  Score, updated each cycle, registered:
//   score_next = score + hit - MISS_PENALTY*(#expired)
//   - saturates at 32'hFFFF_FFFF;
//   - floored at SCORE_FLOOR.
//   miss_pulse=1 if #expired>=1.
//  enable=0: timer, lifetimes, dispatch and hits all frozen; state held; pulses 0.
// CONFIGURATION
//  SPAWNER_STATS_EN defined: adds outputs spawn_count[15:0] (successful pushes) and
//   drop_count[15:0] (overflow_pulse events). Both saturate at 16'hFFFF and reset to 0.
//  Not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  SPAWN_PERIOD=4, LIFE_UNIT=2, ten=3, length=2:
//   push at cycle 3; mask[3]=1 within 2 cycles; expires 6 cycles later;
//   miss_pulse=1; score stays 10 (floor).
//  Hit slot 3 while active -> hit_ok pulse, mask[3]=0, score 10->11, no miss_pulse.
//  ten=12 at spawn -> overflow_pulse=1, queue_count unchanged.
//  Hold hit off, ten=5 for 5 spawns:
//   - head stalls behind active slot 5;
//   - queue_count reaches 4;
//   - 6th spawn -> overflow_pulse.
//  Hit and expiry on slot 7 in the same cycle -> hit_ok=1, miss_pulse=0, score +1.
//  Score 50, two slots expire together -> score 46.
//   Then assert resetn=0 mid-run -> mask=0, queue_count=0, score=10 asynchronously.

Source files
------------

// File: rtl/target_spawner.sv
// target_spawner: queues targets from the random generator, places them on screen,
// times them out and keeps the running score fed back to the generator.
// Build macro SPAWNER_STATS_EN adds saturating spawn_count / drop_count outputs.
module target_spawner #(
  parameter int unsigned SPAWN_PERIOD = 1000,
  parameter int unsigned LIFE_UNIT    = 256,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned MISS_PENALTY = 2,
  parameter int unsigned SCORE_FLOOR  = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [31:0] ran_num_ten,
  input  logic [31:0] ran_num_length,
  input  logic        hit_valid,
  input  logic [3:0]  hit_slot,
  output logic [9:0]  target_mask,
  output logic        hit_ok,
  output logic        miss_pulse,
  output logic        overflow_pulse,
  output logic [2:0]  queue_count,
  output logic [31:0] score
`ifdef SPAWNER_STATS_EN
  ,
  output logic [15:0] spawn_count,
  output logic [15:0] drop_count
`endif
);

  localparam int unsigned NumSlots = 10;
  localparam int unsigned TimerW   = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LifeW    = $clog2(5 * LIFE_UNIT + 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        fifo_slot_q [FIFO_DEPTH];
  logic [2:0]        fifo_life_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [2:0]        count_q;
  logic [9:0]        mask_q, mask_d;
  logic [LifeW-1:0]  life_q [NumSlots];
  logic [LifeW-1:0]  life_d [NumSlots];
  logic [31:0]       score_q, score_d;
  logic              hit_ok_q, hit_ok_d, miss_q, ovf_q;

  logic              spawn_tc, push, drop, pop, head_busy;
  logic [2:0]        new_life;
  logic [3:0]        head_slot;
  logic [2:0]        head_life;
  logic [9:0]        set_vec, hit_vec, exp_vec;
  logic [3:0]        n_expired;
  logic [34:0]       score_up, score_pen;

  assign head_slot = fifo_slot_q[rd_ptr_q];
  assign head_life = fifo_life_q[rd_ptr_q];

  // Spawn timer and push/drop decision at terminal count
  always_comb begin
    spawn_tc = enable && (timer_q == TimerW'(SPAWN_PERIOD - 1));
    timer_d  = timer_q;
    if (enable) timer_d = spawn_tc ? '0 : timer_q + TimerW'(1);
    // A full queue drops even if the head pops this cycle
    push     = spawn_tc && (ran_num_ten <= 32'd9) && (count_q != 3'(FIFO_DEPTH));
    drop     = spawn_tc && !push;
    new_life = 3'(ran_num_length % 32'd5) + 3'd1;
  end

  // Head-of-line dispatch: pop only when the head's slot is free in the registered mask
  always_comb begin
    head_busy = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      if (head_slot == 4'(i)) head_busy = mask_q[i];
    end
    pop = enable && (count_q != 3'd0) && !head_busy;
  end

  // Per-slot activation, hit, lifetime countdown and expiry
  always_comb begin
    set_vec   = '0;
    hit_vec   = '0;
    exp_vec   = '0;
    mask_d    = mask_q;
    n_expired = '0;
    for (int i = 0; i < NumSlots; i++) begin
      set_vec[i] = pop && (head_slot == 4'(i));
      hit_vec[i] = enable && hit_valid && (hit_slot == 4'(i)) && mask_q[i];
      // Hit wins over a coincident expiry
      exp_vec[i] = enable && mask_q[i] && (life_q[i] == LifeW'(1)) && !hit_vec[i];
      mask_d[i]  = (mask_q[i] && !exp_vec[i] && !hit_vec[i]) || set_vec[i];
      life_d[i]  = life_q[i];
      if (set_vec[i]) begin
        life_d[i] = LifeW'(32'(head_life) * LIFE_UNIT);
      end else if (hit_vec[i] || exp_vec[i]) begin
        life_d[i] = '0;
      end else if (enable && mask_q[i]) begin
        life_d[i] = life_q[i] - LifeW'(1);
      end
      n_expired = n_expired + 4'(exp_vec[i]);
    end
    hit_ok_d = |hit_vec;
  end

  // Score update with saturation at the top and SCORE_FLOOR at the bottom
  always_comb begin
    score_up  = {3'b000, score_q} + {34'd0, hit_ok_d};
    score_pen = 35'(MISS_PENALTY) * {31'd0, n_expired};
    if (score_up < score_pen + 35'(SCORE_FLOOR)) begin
      score_d = 32'(SCORE_FLOOR);
    end else if (score_up - score_pen > 35'h0_FFFF_FFFF) begin
      score_d = '1;
    end else begin
      score_d = 32'(score_up - score_pen);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      mask_q   <= '0;
      life_q   <= '{default: '0};
      score_q  <= 32'(SCORE_FLOOR);
      hit_ok_q <= 1'b0;
      miss_q   <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_slot_q[i] <= '0;
        fifo_life_q[i] <= '0;
      end
    end else begin
      timer_q <= timer_d;
      if (push) begin
        fifo_slot_q[wr_ptr_q] <= ran_num_ten[3:0];
        fifo_life_q[wr_ptr_q] <= new_life;
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + 3'd1;
      end else if (pop && !push) begin
        count_q <= count_q - 3'd1;
      end
      mask_q   <= mask_d;
      life_q   <= life_d;
      score_q  <= score_d;
      hit_ok_q <= hit_ok_d;
      miss_q   <= (n_expired != 4'd0);
      ovf_q    <= drop;
    end
  end

`ifdef SPAWNER_STATS_EN
  logic [15:0] spawn_cnt_q, drop_cnt_q;

  // Saturating statistics counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spawn_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (push && (spawn_cnt_q != 16'hFFFF)) spawn_cnt_q <= spawn_cnt_q + 16'd1;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign spawn_count = spawn_cnt_q;
  assign drop_count  = drop_cnt_q;
`endif

  assign target_mask    = mask_q;
  assign hit_ok         = hit_ok_q;
  assign miss_pulse     = miss_q;
  assign overflow_pulse = ovf_q;
  assign queue_count    = count_q;
  assign score          = score_q;

endmodule

// File: tb/tb_target_spawner.sv
// Bench for target_spawner: a queue/array model of the game rules checked every cycle,
// plus directed scenarios pinned with hand-computed values.
// LIFE_UNIT=4 so a length-code-4 target outlives five spawn periods (queue can fill).
module tb_target_spawner;

  localparam int SP = 4;
  localparam int LU = 4;
  localparam int FD = 4;
  localparam int MP = 2;
  localparam int SF = 10;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic [31:0] ran_num_ten;
  logic [31:0] ran_num_length;
  logic        hit_valid;
  logic [3:0]  hit_slot;
  logic [9:0]  target_mask;
  logic        hit_ok;
  logic        miss_pulse;
  logic        overflow_pulse;
  logic [2:0]  queue_count;
  logic [31:0] score;

  target_spawner #(
    .SPAWN_PERIOD(SP),
    .LIFE_UNIT   (LU),
    .FIFO_DEPTH  (FD),
    .MISS_PENALTY(MP),
    .SCORE_FLOOR (SF)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .ran_num_ten   (ran_num_ten),
    .ran_num_length(ran_num_length),
    .hit_valid     (hit_valid),
    .hit_slot      (hit_slot),
    .target_mask   (target_mask),
    .hit_ok        (hit_ok),
    .miss_pulse    (miss_pulse),
    .overflow_pulse(overflow_pulse),
    .queue_count   (queue_count),
    .score         (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct {
    int slot;
    int life;
  } entry_t;

  entry_t m_q[$];
  int     m_rem[10];   // remaining lifetime; a target is on screen while > 0
  int     m_timer;
  longint m_score;
  bit     m_hit, m_miss, m_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int k_now;

  function automatic logic [9:0] model_mask();
    logic [9:0] m;
    m = '0;
    for (int i = 0; i < 10; i++) m[i] = (m_rem[i] > 0);
    return m;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 10; i++) m_rem[i] = 0;
    m_timer = 0;
    m_score = SF;
    m_hit   = 0;
    m_miss  = 0;
    m_ovf   = 0;
  endtask

  task automatic model_step();
    bit     tc, do_hit, do_pop, do_push;
    int     nexp;
    entry_t e;
    longint s;
    if (!enable) begin
      m_hit  = 0;
      m_miss = 0;
      m_ovf  = 0;
      return;
    end
    tc      = (m_timer == SP - 1);
    m_timer = tc ? 0 : m_timer + 1;
    do_hit  = 0;
    if (hit_valid && hit_slot <= 9) do_hit = (m_rem[hit_slot] > 0);
    do_pop  = (m_q.size() > 0) && (m_rem[m_q[0].slot] == 0);
    do_push = tc && (ran_num_ten <= 9) && (m_q.size() < FD);
    nexp    = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_rem[i] > 0) begin
        if (do_hit && hit_slot == i) begin
          m_rem[i] = 0;
        end else begin
          m_rem[i]--;
          if (m_rem[i] == 0) nexp++;
        end
      end
    end
    if (do_pop) begin
      e = m_q.pop_front();
      m_rem[e.slot] = e.life * LU;
    end
    if (do_push) begin
      e.slot = int'(ran_num_ten);
      e.life = int'(ran_num_length % 5) + 1;
      m_q.push_back(e);
    end
    s = m_score + (do_hit ? 1 : 0) - MP * nexp;
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
    if (s < SF) s = SF;
    m_score = s;
    m_hit   = do_hit;
    m_miss  = (nexp > 0);
    m_ovf   = tc && !do_push;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic expect_done(input string name, input bit ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    end
  endtask

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("mask", target_mask, model_mask());
      chk("queue_count", queue_count, m_q.size());
      chk("score", score, m_score);
      chk("hit_ok", hit_ok, m_hit);
      chk("miss_pulse", miss_pulse, m_miss);
      chk("overflow_pulse", overflow_pulse, m_ovf);
    end
  end

  // Advance to the negedge following posedge k of the enabled run
  task automatic adv(input int k);
    repeat (k - k_now) @(negedge clk);
    k_now = k;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int rot;
    resetn         = 1'b0;
    enable         = 1'b0;
    hit_valid      = 1'b0;
    hit_slot       = 4'd0;
    ran_num_ten    = 32'd0;
    ran_num_length = 32'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_mask", target_mask, 0);
    chk("rst_qc", queue_count, 0);
    chk("rst_score", score, 10);
    chk("rst_pulses", {hit_ok, miss_pulse, overflow_pulse}, 0);

    // Spawn, dispatch, expiry into the floor
    enable = 1'b1; ran_num_ten = 3; ran_num_length = 2; k_now = -1;
    adv(3);  chk("push_qc", queue_count, 1); chk("push_mask", target_mask, 0);
    ran_num_ten = 12;
    adv(4);  chk("disp_mask", target_mask, 10'h008); chk("disp_qc", queue_count, 0);
    adv(7);  chk("ovf_pulse", overflow_pulse, 1); chk("ovf_qc", queue_count, 0);
    adv(15); chk("alive_mask", target_mask, 10'h008); chk("alive_miss", miss_pulse, 0);
    adv(16); chk("exp_mask", target_mask, 0); chk("exp_miss", miss_pulse, 1);
    chk("exp_score", score, 10);

    // Hit on an active slot
    ran_num_ten = 3;
    adv(19); chk("push2_qc", queue_count, 1);
    ran_num_ten = 12;
    adv(20); chk("disp2_mask", target_mask, 10'h008);
    adv(21); hit_valid = 1'b1; hit_slot = 4'd3;
    adv(22); chk("hit_ok", hit_ok, 1); chk("hit_mask", target_mask, 0);
    chk("hit_score", score, 11); chk("hit_nomiss", miss_pulse, 0);
    hit_valid = 1'b0;

    // Head-of-line stall on slot 5 until the queue fills
    ran_num_ten = 5; ran_num_length = 4;
    adv(23); chk("stall_qc1", queue_count, 1);
    adv(24); chk("stall_mask", target_mask, 10'h020); chk("stall_qc0", queue_count, 0);
    adv(39); chk("full_qc", queue_count, 4); chk("full_mask", target_mask, 10'h020);
    adv(43); chk("full_ovf", overflow_pulse, 1); chk("full_qc2", queue_count, 4);
    ran_num_ten = 12;
    adv(44); chk("stall_exp_mask", target_mask, 0); chk("stall_exp_miss", miss_pulse, 1);
    chk("stall_exp_score", score, 10);
    adv(45); chk("redisp_mask", target_mask, 10'h020); chk("redisp_qc", queue_count, 3);

    // Ignored hits: out-of-range slot, then inactive slot
    hit_valid = 1'b1; hit_slot = 4'd12;
    adv(46); chk("hit_oor", hit_ok, 0);
    hit_slot = 4'd2;
    adv(47); chk("hit_inactive", hit_ok, 0); chk("hit_inactive_score", score, 10);
    hit_valid = 1'b0;

    // Drain the queued slot-5 targets
    n = 0;
    while ((m_q.size() != 0 || model_mask() != 0) && n < 400) begin
      @(negedge clk); n++;
    end
    expect_done("drain", n < 400);

    // Hit and expiry on slot 7 in the same cycle
    ran_num_ten = 7; ran_num_length = 0;
    n = 0;
    while (m_rem[7] == 0 && n < 20) begin
      @(negedge clk); n++;
    end
    expect_done("slot7_up", n < 20);
    ran_num_ten = 12;
    repeat (3) @(negedge clk);
    hit_valid = 1'b1; hit_slot = 4'd7;
    @(negedge clk);
    hit_valid = 1'b0;
    chk("hx_hit_ok", hit_ok, 1); chk("hx_miss", miss_pulse, 0);
    chk("hx_score", score, 11); chk("hx_mask", target_mask, 0);

    // Build the score up to 50 by hitting every target that appears
    rot = 0; n = 0;
    while (!(m_score == 50 && m_q.size() == 0 && model_mask() == 0) && n < 3000) begin
      hit_valid = 1'b0;
      if (m_score + m_q.size() + $countones(model_mask()) < 50) begin
        ran_num_ten = 32'(rot); ran_num_length = 0;
      end else begin
        ran_num_ten = 12;
      end
      rot = (rot + 1) % 10;
      for (int i = 0; i < 10; i++) begin
        if (m_rem[i] > 0 && !hit_valid) begin
          hit_valid = 1'b1; hit_slot = 4'(i);
        end
      end
      @(negedge clk); n++;
    end
    hit_valid = 1'b0;
    expect_done("reach_50", n < 3000);
    chk("score_50", score, 50);

    // Two targets expiring together, with a pause in between
    ran_num_ten = 1; ran_num_length = 4;
    n = 0;
    while (m_rem[1] == 0 && n < 20) begin
      @(negedge clk); n++;
    end
    expect_done("slot1_up", n < 20);
    ran_num_ten = 2; ran_num_length = 3;
    n = 0;
    while (m_rem[2] == 0 && n < 20) begin
      @(negedge clk); n++;
    end
    expect_done("slot2_up", n < 20);
    ran_num_ten = 12;
    chk("two_live", target_mask, 10'h006);
    enable = 1'b0; hit_valid = 1'b1; hit_slot = 4'd1;
    repeat (5) @(negedge clk);
    chk("pause_mask", target_mask, 10'h006); chk("pause_hit", hit_ok, 0);
    chk("pause_score", score, 50);
    hit_valid = 1'b0; enable = 1'b1;
    n = 0;
    while (model_mask() != 0 && n < 40) begin
      @(negedge clk); n++;
    end
    expect_done("double_exp", n < 40);
    chk("double_score", score, 46); chk("double_miss", miss_pulse, 1);
    chk("double_mask", target_mask, 0);

    // Asynchronous reset with an active target and a queued entry
    ran_num_ten = 4; ran_num_length = 4;
    n = 0;
    while (!(m_rem[4] > 0 && m_q.size() >= 1) && n < 40) begin
      @(negedge clk); n++;
    end
    expect_done("pre_reset", n < 40);
    #2 resetn = 1'b0;
    #1;
    chk("areset_mask", target_mask, 0); chk("areset_qc", queue_count, 0);
    chk("areset_score", score, 10);
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
